// File: rtl/sensor_hub_if.sv
// Request/response bundle between the UART command layer and sensor_hub.
// The master side issues requests; the hub (slave) answers with responses.
interface sensor_hub_if;
    logic       enable;
    logic       stop_button;
    logic [7:0] request_command;
    logic [7:0] request_address;
    logic       busy;
    logic       response_valid;
    logic [7:0] response_command;
    logic [7:0] response_value;

    modport master (
        output enable,
        output stop_button,
        output request_command,
        output request_address,
        input  busy,
        input  response_valid,
        input  response_command,
        input  response_value
    );

    modport slave (
        input  enable,
        input  stop_button,
        input  request_command,
        input  request_address,
        output busy,
        output response_valid,
        output response_command,
        output response_value
    );
endinterface

// File: rtl/sensor_hub.sv
// Multi-channel 40-bit sensor hub: command decode, per-channel reads with
// checksum/timeout, response pairs and a periodic read loop on one channel.
module sensor_hub #(
    parameter int NUM_SENSORS     = 4,
    parameter int LOOP_PERIOD_CYC = 100_000_000,
    parameter int TIMEOUT_CYC     = 5_000_000
) (
    input  logic                      clock,
    input  logic                      reset_n,
    sensor_hub_if.slave               hub,
    input  logic [40*NUM_SENSORS-1:0] sensor_data,
    input  logic [NUM_SENSORS-1:0]    sensor_done,
    input  logic [NUM_SENSORS-1:0]    sensor_error,
    output logic [NUM_SENSORS-1:0]    sensor_enable
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int PW = (LOOP_PERIOD_CYC > 1) ? $clog2(LOOP_PERIOD_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(LOOP_PERIOD_CYC - 1);
    localparam logic [8:0]    NS       = 9'(NUM_SENSORS);

    localparam logic [7:0] C_AC   = 8'hAC;
    localparam logic [7:0] C_TEMP = 8'h01;
    localparam logic [7:0] C_HUM  = 8'h02;
    localparam logic [7:0] C_LT   = 8'h03;
    localparam logic [7:0] C_LH   = 8'h04;
    localparam logic [7:0] C_ST5  = 8'h05;
    localparam logic [7:0] C_ST6  = 8'h06;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_RESP,
        S_LOOP
    } state_t;

    state_t        state_q, state_d;
    logic          en_q;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    addr_q, addr_d;
    logic          loop_on_q, loop_on_d;
    logic          loop_kind_q, loop_kind_d;
    logic [7:0]    loop_addr_q, loop_addr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [PW-1:0] per_q, per_d;
    logic          rvalid_q, rvalid_d;
    logic [7:0]    rcmd_q, rcmd_d;
    logic [7:0]    rval_q, rval_d;

    logic [39:0] sel_data;
    logic        sel_done;
    logic        sel_err;

    always_comb begin
        sel_data = '0;
        sel_done = 1'b0;
        sel_err  = 1'b0;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            if (addr_q == 8'(k)) begin
                sel_data = sensor_data[40*k +: 40];
                sel_done = sensor_done[k];
                sel_err  = sensor_error[k];
            end
        end
    end

    always_comb begin
        sensor_enable = '0;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            sensor_enable[k] = (state_q == S_READ) && (addr_q == 8'(k));
        end
    end

    logic [7:0] hum, hum_d, temp, temp_d, sum, csum;
    logic       rd_exit, rd_ok;

    assign hum     = sel_data[39:32];
    assign hum_d   = sel_data[31:24];
    assign temp    = sel_data[23:16];
    assign temp_d  = sel_data[15:8];
    assign sum     = sel_data[7:0];
    assign csum    = hum + hum_d + temp + temp_d;
    assign rd_exit = sel_done || sel_err || (tmo_q == TMO_LAST);
    assign rd_ok   = sel_done && !sel_err && (csum == sum);

    function automatic logic [15:0] read_resp(
        input logic [7:0] cmd,
        input logic       ok,
        input logic [7:0] h,
        input logic [7:0] t
    );
        logic [15:0] r;
        r = 16'h1F1F;
        if (ok) begin
            unique case (cmd)
                C_AC:    r = 16'h0707;
                C_TEMP:  r = {8'h09, t};
                C_HUM:   r = {8'h08, h};
                C_LT:    r = {8'h0D, t};
                C_LH:    r = {8'h0E, h};
                default: r = 16'h1F1F;
            endcase
        end
        return r;
    endfunction

    logic        accept;
    logic        bad_addr;
    logic        is_stop;
    logic        is_loopcmd;
    logic        is_readcmd;
    logic        imm;
    logic [15:0] imm_resp;
    logic [15:0] rd_resp;

    assign accept = hub.enable && !en_q &&
                    ((state_q == S_IDLE) || (state_q == S_LOOP));
    assign bad_addr   = {1'b0, hub.request_address} >= NS;
    assign is_stop    = (hub.request_command == C_ST5) ||
                        (hub.request_command == C_ST6);
    assign is_loopcmd = (hub.request_command == C_LT) ||
                        (hub.request_command == C_LH);
    assign is_readcmd = is_loopcmd ||
                        (hub.request_command == C_AC) ||
                        (hub.request_command == C_TEMP) ||
                        (hub.request_command == C_HUM);
    assign rd_resp    = read_resp(cmd_q, rd_ok, hum, temp);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        loop_on_d   = loop_on_q;
        loop_kind_d = loop_kind_q;
        loop_addr_d = loop_addr_q;
        tmo_d       = '0;
        per_d       = '0;
        rvalid_d    = 1'b0;
        rcmd_d      = rcmd_q;
        rval_d      = rval_q;
        imm         = 1'b0;
        imm_resp    = '0;

        case (state_q)
            S_IDLE, S_LOOP: begin
                if (accept) begin
                    cmd_d  = hub.request_command;
                    addr_d = hub.request_address;
                    imm    = 1'b1;
                    if (bad_addr) begin
                        imm_resp = {8'hFE, hub.request_address};
                    end else if (is_stop) begin
                        loop_on_d = 1'b0;
                        imm_resp  = (hub.request_command == C_ST5) ?
                                    16'h0A0A : 16'h0B0B;
                    end else if (is_loopcmd ||
                                 (is_readcmd && state_q == S_IDLE)) begin
                        imm     = 1'b0;
                        state_d = S_READ;
                    end else if (state_q == S_LOOP) begin
                        imm_resp = 16'hFFFF;
                    end else begin
                        imm_resp = 16'h4545;
                    end
                end else if (state_q == S_LOOP) begin
                    // Periodic read reuses the 03/04 read path on loop_addr.
                    if (per_q == PER_LAST) begin
                        state_d = S_READ;
                        addr_d  = loop_addr_q;
                        cmd_d   = loop_kind_q ? C_LH : C_LT;
                    end else begin
                        per_d = per_q + 1'b1;
                    end
                end
            end
            S_READ: begin
                tmo_d = tmo_q + 1'b1;
                if (rd_exit) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    {rcmd_d, rval_d} = rd_resp;
                    if (rd_ok && (cmd_q == C_LT || cmd_q == C_LH)) begin
                        loop_on_d   = 1'b1;
                        loop_addr_d = addr_q;
                        loop_kind_d = (cmd_q == C_LH);
                    end
                end
            end
            S_RESP: begin
                state_d = loop_on_q ? S_LOOP : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (imm) begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            {rcmd_d, rval_d} = imm_resp;
        end

        if (hub.stop_button) begin
            state_d   = S_IDLE;
            loop_on_d = 1'b0;
            tmo_d     = '0;
            per_d     = '0;
            rvalid_d  = 1'b0;
            rcmd_d    = rcmd_q;
            rval_d    = rval_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            en_q        <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
            loop_on_q   <= 1'b0;
            loop_kind_q <= 1'b0;
            loop_addr_q <= '0;
            tmo_q       <= '0;
            per_q       <= '0;
            rvalid_q    <= 1'b0;
            rcmd_q      <= '0;
            rval_q      <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= hub.enable;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            loop_on_q   <= loop_on_d;
            loop_kind_q <= loop_kind_d;
            loop_addr_q <= loop_addr_d;
            tmo_q       <= tmo_d;
            per_q       <= per_d;
            rvalid_q    <= rvalid_d;
            rcmd_q      <= rcmd_d;
            rval_q      <= rval_d;
        end
    end

    assign hub.busy = (state_q == S_READ) || (state_q == S_RESP);
    assign hub.response_valid   = rvalid_q;
    assign hub.response_command = rcmd_q;
    assign hub.response_value   = rval_q;
endmodule
